// File: rtl/boe_pkg.sv
// Shared tags, FSM states and mode bit positions for the batch-of-elements
// statistic block.
package boe_pkg;

  localparam int unsigned TAG_W  = 2;
  localparam int unsigned MODE_W = 2;

  localparam logic [TAG_W-1:0] TAG_SUM  = 2'd0;
  localparam logic [TAG_W-1:0] TAG_EXT  = 2'd1;
  localparam logic [TAG_W-1:0] TAG_SORT = 2'd2;

  localparam int unsigned MODE_ASC    = 0;
  localparam int unsigned MODE_NOSORT = 1;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SUM  = 2'd1,
    EXT  = 2'd2,
    SORT = 2'd3
  } state_e;

endpackage

// File: rtl/boe_param_if.sv
// Sample input stream plus tagged result stream of boe_param.
interface boe_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_N  = 6
);
  localparam int unsigned NUM_W = $clog2(MAX_N + 1);
  localparam int unsigned SUM_W = DATA_W + $clog2(MAX_N + 1);

  logic              in_valid;
  logic              in_ready;
  logic [NUM_W-1:0]  data_num;
  logic [1:0]        mode;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_tag;
  logic              out_last;
  logic [SUM_W-1:0]  result;

  modport master (
    output in_valid, data_num, mode, data_in, out_ready,
    input  in_ready, out_valid, out_tag, out_last, result
  );

  modport slave (
    input  in_valid, data_num, mode, data_in, out_ready,
    output in_ready, out_valid, out_tag, out_last, result
  );
endinterface

// File: rtl/boe_sort_insert.sv
// Ordered MAX_N-entry register array: single-cycle insert keeps it sorted,
// pop removes the head and shifts the rest towards index 0.
module boe_sort_insert #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_N  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ins,
  input  logic [DATA_W-1:0] ins_data,
  input  logic              asc,
  input  logic              pop,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] arr_q [MAX_N];
  logic [DATA_W-1:0] arr_d [MAX_N];
  logic [MAX_N-1:0]  vld_q, vld_d;
  logic [MAX_N-1:0]  gt;

  // gt is monotone over the valid prefix, so the first set bit is the slot
  always_comb begin
    for (int i = 0; i < int'(MAX_N); i++) begin
      gt[i] = !vld_q[i] || (asc ? (ins_data < arr_q[i]) : (ins_data > arr_q[i]));
    end
  end

  always_comb begin
    arr_d = arr_q;
    vld_d = vld_q;
    if (clr) begin
      for (int i = 0; i < int'(MAX_N); i++) arr_d[i] = '0;
      vld_d = '0;
    end else if (ins) begin
      if (gt[0]) begin
        arr_d[0] = ins_data;
        vld_d[0] = 1'b1;
      end
      for (int i = 1; i < int'(MAX_N); i++) begin
        if (gt[i]) begin
          if (gt[i-1]) begin
            arr_d[i] = arr_q[i-1];
            vld_d[i] = vld_q[i-1];
          end else begin
            arr_d[i] = ins_data;
            vld_d[i] = 1'b1;
          end
        end
      end
    end else if (pop) begin
      for (int i = 0; i < int'(MAX_N) - 1; i++) begin
        arr_d[i] = arr_q[i+1];
        vld_d[i] = vld_q[i+1];
      end
      arr_d[MAX_N-1] = '0;
      vld_d[MAX_N-1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(MAX_N); i++) arr_q[i] <= '0;
      vld_q <= '0;
    end else begin
      arr_q <= arr_d;
      vld_q <= vld_d;
    end
  end

  assign head = arr_q[0];

endmodule

// File: rtl/boe_param.sv
// Batch statistic block: loads 1..MAX_N samples, then emits SUM, EXT and
// (optionally) the sorted batch on a tagged valid/ready stream.
module boe_param
  import boe_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_N  = 6
) (
  input logic       clk,
  input logic       rst,
  boe_param_if.slave bus
);

  localparam int unsigned NUM_W = $clog2(MAX_N + 1);
  localparam int unsigned SUM_W = DATA_W + $clog2(MAX_N + 1);

  state_e            state_q, state_d;
  logic [NUM_W-1:0]  cnt_q, cnt_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic [NUM_W-1:0]  ocnt_q, ocnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] ext_q, ext_d;

  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              last_q, last_d;
  logic [SUM_W-1:0]  result_q, result_d;

  logic              srt_clr, srt_ins, srt_pop, srt_asc;
  logic [DATA_W-1:0] head;

  logic              beat, first, bad_num, out_hs, better, go_load;
  logic [NUM_W-1:0]  cnt_inc, num_eff;
  logic [SUM_W-1:0]  sum_acc;
  logic [DATA_W-1:0] ext_acc;

  boe_sort_insert #(.DATA_W(DATA_W), .MAX_N(MAX_N)) u_sort (
    .clk      (clk),
    .rst      (rst),
    .clr      (srt_clr),
    .ins      (srt_ins),
    .ins_data (bus.data_in),
    .asc      (srt_asc),
    .pop      (srt_pop),
    .head     (head)
  );

  // Next-state, accumulator and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    ocnt_d      = ocnt_q;
    mode_d      = mode_q;
    sum_d       = sum_q;
    ext_d       = ext_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    tag_d       = tag_q;
    last_d      = last_q;
    result_d    = result_q;
    srt_clr     = 1'b0;
    srt_ins     = 1'b0;
    srt_pop     = 1'b0;
    go_load     = 1'b0;

    beat    = bus.in_valid && (state_q == LOAD);
    first   = (cnt_q == '0);
    bad_num = (bus.data_num == '0) || (bus.data_num > NUM_W'(MAX_N));
    srt_asc = first ? bus.mode[MODE_ASC] : mode_q[MODE_ASC];
    out_hs  = out_valid_q && bus.out_ready;
    cnt_inc = cnt_q + NUM_W'(1);
    num_eff = first ? bus.data_num : num_q;
    sum_acc = (first ? '0 : sum_q) + SUM_W'(bus.data_in);
    better  = srt_asc ? (bus.data_in < ext_q) : (bus.data_in > ext_q);
    ext_acc = (first || better) ? bus.data_in : ext_q;

    case (state_q)
      LOAD: begin
        if (beat && !(first && bad_num)) begin
          srt_ins = 1'b1;
          sum_d   = sum_acc;
          ext_d   = ext_acc;
          cnt_d   = cnt_inc;
          if (first) begin
            num_d  = bus.data_num;
            mode_d = bus.mode;
          end
          if (cnt_inc == num_eff) begin
            state_d     = SUM;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            tag_d       = TAG_SUM;
            last_d      = 1'b0;
            result_d    = sum_acc;
          end
        end
      end
      SUM: begin
        if (out_hs) begin
          state_d  = EXT;
          tag_d    = TAG_EXT;
          result_d = SUM_W'(ext_q);
          last_d   = mode_q[MODE_NOSORT];
        end
      end
      EXT: begin
        if (out_hs) begin
          if (mode_q[MODE_NOSORT]) begin
            go_load = 1'b1;
          end else begin
            // Sorter runs one ahead: the head is latched and popped together
            state_d  = SORT;
            tag_d    = TAG_SORT;
            result_d = SUM_W'(head);
            srt_pop  = 1'b1;
            ocnt_d   = NUM_W'(1);
            last_d   = (num_q == NUM_W'(1));
          end
        end
      end
      SORT: begin
        if (out_hs) begin
          if (last_q) begin
            go_load = 1'b1;
          end else begin
            result_d = SUM_W'(head);
            srt_pop  = 1'b1;
            ocnt_d   = ocnt_q + NUM_W'(1);
            last_d   = ((ocnt_q + NUM_W'(1)) == num_q);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    if (go_load) begin
      state_d     = LOAD;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      tag_d       = TAG_SUM;
      last_d      = 1'b0;
      result_d    = '0;
      srt_clr     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      num_q       <= '0;
      ocnt_q      <= '0;
      mode_q      <= '0;
      sum_q       <= '0;
      ext_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      tag_q       <= TAG_SUM;
      last_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      ocnt_q      <= ocnt_d;
      mode_q      <= mode_d;
      sum_q       <= sum_d;
      ext_q       <= ext_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      tag_q       <= tag_d;
      last_q      <= last_d;
      result_q    <= result_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_tag   = tag_q;
  assign bus.out_last  = last_q;
  assign bus.result    = result_q;

endmodule
